// File: rtl/rx_preamble_strip.sv
// rx_preamble_strip
//   GMII receive front end. Locks onto preamble + SFD, strips both, and holds
//   post-SFD bytes in a 4-byte delay line so that the trailing FCS is never
//   forwarded. The payload leaves on rx_data/rx_enable with an enable that is
//   gap-free for the whole frame. A one-cycle frame_done pulse reports the
//   payload length and the frame status.
//
//   Optional feature: define RX_FCS_CHECK_EN to build a reflected CRC-32 over
//   every post-SFD byte; frame_ok then also requires the good-FCS residue.
//
// Ports:
//   rx_clk      GMII receive clock, all logic on the rising edge
//   reset       asynchronous, active-high reset
//   gmii_rxd    raw GMII receive byte
//   gmii_rx_dv  GMII data valid
//   gmii_rx_er  GMII receive error (only honoured inside the payload)
//   rx_data     payload byte (preamble/SFD/FCS removed), holds when idle
//   rx_enable   rx_data valid
//   frame_done  one-cycle pulse at the end of each accepted frame
//   frame_ok    frame status, valid with frame_done
//   byte_count  payload bytes forwarded (FCS excluded), valid with frame_done
module rx_preamble_strip #(
  parameter int unsigned MIN_PREAMBLE = 2,
  parameter int unsigned MAX_LEN      = 1518
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_enable,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [10:0] byte_count
);

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP,
    FRAME_END
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  sr_q [4];
  logic [7:0]  sr_d [4];
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_enable_q, rx_enable_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [10:0] byte_count_q, byte_count_d;
  logic        crc_ok;

`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_ok = (crc_q == 32'hDEBB20E3);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    len_d        = len_q;
    sr_d         = sr_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    rx_data_d    = rx_data_q;
    rx_enable_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    byte_count_d = byte_count_q;
`ifdef RX_FCS_CHECK_EN
    crc_d        = crc_q;
`endif

    unique case (state_q)
      WAIT_IDLE: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PRE_BYTE) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (gmii_rxd == PRE_BYTE) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (gmii_rxd == SFD_BYTE && 32'(pre_cnt_q) >= MIN_PREAMBLE) begin
          state_d = PAYLOAD;
          len_d   = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
`ifdef RX_FCS_CHECK_EN
          crc_d   = '1;
`endif
        end else begin
          state_d = DROP;
        end
      end
      PAYLOAD: begin
        if (!gmii_rx_dv) begin
          // Status is computed on the transition so it is visible during FRAME_END;
          // the delay line still holds the FCS and is simply never forwarded.
          state_d      = FRAME_END;
          frame_done_d = 1'b1;
          byte_count_d = (len_q >= 11'd4) ? (len_q - 11'd4) : '0;
          frame_ok_d   = !err_q && !ovf_q && (len_q >= 11'd4) && crc_ok;
        end else begin
          if (gmii_rx_er) err_d = 1'b1;
          if (len_q == LEN_MAX) begin
            // Overlong: stop shifting and forwarding, enable drops.
            ovf_d = 1'b1;
          end else begin
            sr_d[0] = gmii_rxd;
            sr_d[1] = sr_q[0];
            sr_d[2] = sr_q[1];
            sr_d[3] = sr_q[2];
            len_d   = len_q + 11'd1;
`ifdef RX_FCS_CHECK_EN
            crc_d   = crc32_byte(crc_q, gmii_rxd);
`endif
            if (len_q >= 11'd4) begin
              rx_data_d   = sr_q[3];
              rx_enable_d = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      FRAME_END: begin
        if (gmii_rx_dv && gmii_rxd == PRE_BYTE) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_IDLE;
      pre_cnt_q    <= '0;
      len_q        <= '0;
      sr_q         <= '{default: '0};
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_enable_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      byte_count_q <= '0;
`ifdef RX_FCS_CHECK_EN
      crc_q        <= '1;
`endif
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      len_q        <= len_d;
      sr_q         <= sr_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      rx_data_q    <= rx_data_d;
      rx_enable_q  <= rx_enable_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      byte_count_q <= byte_count_d;
`ifdef RX_FCS_CHECK_EN
      crc_q        <= crc_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_enable  = rx_enable_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rx_preamble_strip.sv
// tb_rx_preamble_strip
//   Directed bench for rx_preamble_strip: drives GMII frames, collects the
//   forwarded payload and frame_done reports, and compares them with
//   hand-computed expectations.
module tb_rx_preamble_strip;

  logic        rx_clk = 1'b0;
  logic        reset;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  rx_data;
  logic        rx_enable;
  logic        frame_done;
  logic        frame_ok;
  logic [10:0] byte_count;

  rx_preamble_strip #(.MIN_PREAMBLE(2), .MAX_LEN(1518)) dut (
    .rx_clk     (rx_clk),
    .reset      (reset),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .rx_data    (rx_data),
    .rx_enable  (rx_enable),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .byte_count (byte_count)
  );

  always #4 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc++;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor
  logic [7:0] q_data [$];
  logic       q_ok   [$];
  int         q_cnt  [$];
  int         en_rises;
  int         first_en_cyc;
  int         first_cyc;
  logic       en_prev = 1'b0;

  always @(negedge rx_clk) begin
    if (rx_enable === 1'b1) begin
      if (q_data.size() == 0) first_en_cyc = cyc;
      q_data.push_back(rx_data);
      if (!en_prev) en_rises++;
    end
    en_prev = (rx_enable === 1'b1);
    if (frame_done === 1'b1) begin
      q_ok.push_back(frame_ok);
      q_cnt.push_back(int'(byte_count));
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_ok.delete();
    q_cnt.delete();
    en_rises     = 0;
    first_en_cyc = -1;
  endtask

  logic [7:0] pl [0:1599];

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge rx_clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  // npre x 0x55, SFD, pl[0..nlen-1]; er_at/rst_at = -1 to disable
  task automatic send_frame(input int npre, input int nlen, input int er_at, input int rst_at);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < nlen; i++) begin
      drive(1'b1, pl[i], i == er_at);
      if (i == 0) first_cyc = cyc;
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", 32'({rx_data, rx_enable, frame_done, frame_ok, byte_count}), 32'h0);
        clear_mon();
      end
      if (rst_at >= 0 && i == rst_at + 3) reset = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int exp_bytes, input int exp_done,
                             input logic exp_ok, input int exp_cnt, input int period);
    int nbad;
    nbad = 0;
    check({tag, "_nbytes"}, 32'(q_data.size()), 32'(exp_bytes));
    check({tag, "_en_rises"}, 32'(en_rises), (exp_bytes > 0) ? 32'd1 : 32'd0);
    if (q_data.size() > 0) begin
      foreach (q_data[i]) if (q_data[i] !== pl[i % period]) nbad++;
      check({tag, "_data_errs"}, 32'(nbad), 32'd0);
    end
    check({tag, "_done_cnt"}, 32'(q_ok.size()), 32'(exp_done));
    if (q_ok.size() > 0) begin
      check({tag, "_frame_ok"}, 32'(q_ok[q_ok.size()-1]), 32'(exp_ok));
      check({tag, "_byte_count"}, 32'(q_cnt[q_cnt.size()-1]), 32'(exp_cnt));
    end
  endtask

  function automatic logic [31:0] crc32(input int n);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      r = r ^ {24'h0, pl[i]};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  logic [31:0] fcs;
  logic        exp_bad_fcs_ok;

  initial begin
    reset      = 1'b1;
    gmii_rx_dv = 1'b1;
    gmii_rxd   = 8'hAA;
    gmii_rx_er = 1'b0;
    clear_mon();
    first_cyc = 0;
    repeat (3) @(posedge rx_clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_enable", 32'(rx_enable), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    check("reset_frame_ok", 32'(frame_ok), 32'h0);
    check("reset_byte_count", 32'(byte_count), 32'h0);
    reset = 1'b0;
    idle(3);

    // Basic 64-byte frame with 7-byte preamble
    for (int i = 0; i < 64; i++) pl[i] = 8'(i);
    clear_mon();
    send_frame(7, 64, -1, -1);
    idle(8);
    check_frame("basic", 60, 1, 1'b1, 60, 100000);
    check("basic_latency", 32'(first_en_cyc - first_cyc), 32'd5);

    // Preamble too short: dropped
    clear_mon();
    send_frame(1, 64, -1, -1);
    idle(8);
    check_frame("short_pre", 0, 0, 1'b0, 0, 100000);

    // Exactly MIN_PREAMBLE with a 4-byte frame: accepted, nothing forwarded
    clear_mon();
    send_frame(2, 4, -1, -1);
    idle(8);
    check_frame("len4", 0, 1, 1'b1, 0, 100000);

    // rx_er on byte 10
    clear_mon();
    send_frame(7, 64, 10, -1);
    idle(8);
    check_frame("rx_er", 60, 1, 1'b0, 60, 100000);

    // Reset mid frame, released while rx_dv is still high
    clear_mon();
    send_frame(7, 64, -1, 20);
    idle(8);
    check_frame("rst_rest", 0, 0, 1'b0, 0, 100000);
    clear_mon();
    send_frame(7, 64, -1, -1);
    idle(8);
    check_frame("after_rst", 60, 1, 1'b1, 60, 100000);

    // Back-to-back frames with a single-cycle gap, then a 3-byte frame
    clear_mon();
    send_frame(7, 64, -1, -1);
    idle(1);
    send_frame(7, 64, -1, -1);
    idle(8);
    check("b2b_nbytes", 32'(q_data.size()), 32'd120);
    check("b2b_en_rises", 32'(en_rises), 32'd2);
    check("b2b_done_cnt", 32'(q_ok.size()), 32'd2);
    if (q_ok.size() == 2) begin
      check("b2b_ok0", 32'(q_ok[0]), 32'd1);
      check("b2b_cnt0", 32'(q_cnt[0]), 32'd60);
      check("b2b_ok1", 32'(q_ok[1]), 32'd1);
      check("b2b_cnt1", 32'(q_cnt[1]), 32'd60);
    end
    if (q_data.size() == 120) begin
      check("b2b_f2_first", 32'(q_data[60]), 32'h00);
      check("b2b_f2_last", 32'(q_data[119]), 32'h3B);
    end
    clear_mon();
    send_frame(7, 3, -1, -1);
    idle(8);
    check_frame("len3", 0, 1, 1'b0, 0, 100000);

    // Exactly MAX_LEN, then overlong
    for (int i = 0; i < 1600; i++) pl[i] = 8'(i * 3 + 1);
    clear_mon();
    send_frame(7, 1518, -1, -1);
    idle(8);
    check_frame("max_len", 1514, 1, 1'b1, 1514, 100000);
    clear_mon();
    send_frame(7, 1520, -1, -1);
    idle(8);
    check_frame("overlong", 1514, 1, 1'b0, 1514, 100000);

    // Frame with a correct FCS, then with one FCS bit flipped
    for (int i = 0; i < 60; i++) pl[i] = 8'(i * 37 + 5);
    fcs = ~crc32(60);
    for (int k = 0; k < 4; k++) pl[60 + k] = fcs[8*k +: 8];
    clear_mon();
    send_frame(7, 64, -1, -1);
    idle(8);
    check_frame("fcs_good", 60, 1, 1'b1, 60, 100000);
    pl[62] = pl[62] ^ 8'h10;
`ifdef RX_FCS_CHECK_EN
    exp_bad_fcs_ok = 1'b0;
`else
    exp_bad_fcs_ok = 1'b1;
`endif
    clear_mon();
    send_frame(7, 64, -1, -1);
    idle(8);
    check_frame("fcs_bad", 60, 1, exp_bad_fcs_ok, 60, 100000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
